// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
// Module      : result_collector
// Description : Gathers NUM_RES ALU result words into a local buffer, tracks
//               the running unsigned maximum and replays the words in order
//               over a valid/ready stream, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module result_collector #(
    parameter int DATA_W  = 19,
    parameter int NUM_RES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] max_val,
    output logic              busy,
    output logic              done,
    output logic              err_drop
);

    localparam int c_PTR_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(NUM_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_READOUT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0]   r_max_val;
    logic                r_err_drop;
    logic [DATA_W-1:0]   r_buf [NUM_RES];

    logic                w_accept;
    logic                w_drop;

    // A word is taken only while collecting; any other valid word is lost
    assign w_accept = (r_state == S_COLLECT) && res_valid;
    assign w_drop   = (r_state != S_COLLECT) && res_valid;

    // Control FSM with pointers, running maximum and sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_max_val  <= '0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    // A new job clears the statistics of the previous one
                    if (start_in) begin
                        r_state    <= S_COLLECT;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_max_val  <= '0;
                        r_err_drop <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (res_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (res_data > r_max_val) begin
                            r_max_val <= res_data;
                        end
                        if (r_wr_ptr == c_LAST_IDX) begin
                            r_state <= S_READOUT;
                        end
                    end
                end
                S_READOUT: begin
                    if (out_ready) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        if (r_rd_ptr == c_LAST_IDX) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result storage; contents are never read before being written in a job
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= res_data;
        end
    end

    // Outputs decode directly from the state register so reset acts at once
    assign res_ready = (r_state == S_COLLECT);
    assign out_valid = (r_state == S_READOUT);
    assign out_data  = (r_state == S_READOUT) ? r_buf[r_rd_ptr] : '0;
    assign out_last  = (r_state == S_READOUT) && (r_rd_ptr == c_LAST_IDX);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign max_val   = r_max_val;
    assign err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_collector
// Description : Directed self-checking bench for result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_collector;

    localparam int DATA_W  = 19;
    localparam int NUM_RES = 16;

    logic              clk;
    logic              rst;
    logic              start_in;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [DATA_W-1:0] max_val;
    logic              busy;
    logic              done;
    logic              err_drop;

    int                check_cnt;
    int                pass_cnt;
    logic [DATA_W-1:0] vec [NUM_RES];

    result_collector #(
        .DATA_W  (DATA_W),
        .NUM_RES (NUM_RES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .max_val   (max_val),
        .busy      (busy),
        .done      (done),
        .err_drop  (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks begin and end just after a falling edge
    task automatic start_job();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        check("collect_busy", 32'(busy), 1);
        check("collect_ready", 32'(res_ready), 1);
    endtask

    task automatic feed(input int count);
        for (int i = 0; i < count; i++) begin
            res_valid = 1'b1;
            res_data  = vec[i];
            @(negedge clk);
        end
        res_valid = 1'b0;
        res_data  = '0;
    endtask

    task automatic readout(input bit toggle, input int start_at);
        int  idx;
        int  cyc;
        bit  pulsed;
        idx    = 0;
        cyc    = 0;
        pulsed = 1'b0;
        while (idx < NUM_RES && cyc < 200) begin
            check("rd_valid", 32'(out_valid), 1);
            check("rd_data", 32'(out_data), 32'(vec[idx]));
            check("rd_last", 32'(out_last), (idx == NUM_RES - 1) ? 1 : 0);
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            start_in  = (idx == start_at) && !pulsed;
            if (start_in) pulsed = 1'b1;
            @(negedge clk);
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        start_in  = 1'b0;
        if (idx < NUM_RES) check("rd_timeout", 0, 1);
        check("done_pulse", 32'(done), 1);
        check("done_no_valid", 32'(out_valid), 0);
        check("done_data_zero", 32'(out_data), 0);
        @(negedge clk);
        check("idle_done_low", 32'(done), 0);
        check("idle_busy_low", 32'(busy), 0);
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b1;
        start_in  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(res_ready), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_max", 32'(max_val), 0);
        check("rst_err", 32'(err_drop), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Ascending 0..15 with continuous readout
        for (int i = 0; i < NUM_RES; i++) vec[i] = DATA_W'(i);
        start_job();
        feed(NUM_RES);
        check("t1_latency_valid", 32'(out_valid), 1);
        readout(1'b0, -1);
        check("t1_max", 32'(max_val), 15);

        // Mixed data with a stalling consumer
        vec = '{19'd5, 19'd900, 19'd3, 19'd17, 19'd42, 19'd0, 19'd899, 19'd1,
                19'd256, 19'd128, 19'd64, 19'd32, 19'd16, 19'd8, 19'd4, 19'd2};
        start_job();
        feed(NUM_RES);
        readout(1'b1, -1);
        check("t2_max", 32'(max_val), 900);

        // Word offered while idle is dropped and flagged
        res_valid = 1'b1;
        res_data  = 19'd7;
        @(negedge clk);
        res_valid = 1'b0;
        res_data  = '0;
        check("t3_err_set", 32'(err_drop), 1);
        check("t3_max_kept", 32'(max_val), 900);
        start_job();
        check("t3_err_clr", 32'(err_drop), 0);
        check("t3_max_clr", 32'(max_val), 0);

        // Start pulse during readout of word 4 is ignored
        for (int i = 0; i < NUM_RES; i++) vec[i] = DATA_W'(100 + 3 * i);
        feed(NUM_RES);
        readout(1'b0, 4);
        check("t4_max", 32'(max_val), 145);
        check("t4_err", 32'(err_drop), 0);

        // Reset after nine accepted words aborts the job
        for (int i = 0; i < NUM_RES; i++) vec[i] = DATA_W'(1000 - 7 * i);
        start_job();
        feed(9);
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_ready", 32'(res_ready), 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_data", 32'(out_data), 0);
        check("t5_max", 32'(max_val), 0);
        check("t5_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_no_done", 32'(done), 0);
        check("t5_stay_idle", 32'(busy), 0);
        start_job();
        feed(NUM_RES);
        readout(1'b0, -1);
        check("t5_max_new", 32'(max_val), 1000);

        // Full-scale word first, then zeros
        for (int i = 0; i < NUM_RES; i++) vec[i] = '0;
        vec[0] = 19'd524287;
        start_job();
        feed(NUM_RES);
        readout(1'b1, -1);
        check("t6_max", 32'(max_val), 524287);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
